// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage plus IF/ID pipeline register.
//
// Holds the PC, drives it combinationally to instruction memory and
// registers the returned word into IF/ID. Honours the stall unit's
// PC_WriteEn / IFID_WriteEn, squashes the wrong-path fetch on a branch or
// jump redirect, and counts stall and redirect cycles (saturating).
//
// Ports:
//   clk, reset_n          clock (rising edge), async active-low reset
//   PC_WriteEn            0 = hold PC
//   IFID_WriteEn          0 = hold IF/ID register
//   Stall_flush           1 = load-use stall cycle (counted only)
//   redirect, redirect_target   branch/jump from ID
//   imem_addr / imem_rdata      instruction memory (combinational read)
//   IFID_Instr, IFID_PC4, IFID_Valid   IF/ID register outputs
//   stall_cnt, redirect_cnt     saturating performance counters
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             PC_WriteEn,
    input  logic             IFID_WriteEn,
    input  logic             Stall_flush,
    input  logic             redirect,
    input  logic [31:0]      redirect_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      IFID_Instr,
    output logic [31:0]      IFID_PC4,
    output logic             IFID_Valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic {BOOT, RUN} state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc4_q, pc4_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

    logic [31:0]      pc_plus4;
    logic             redirect_acc;

    assign pc_plus4 = pc_q + 32'd4;
    // A redirect is only taken when the PC is allowed to move; while the PC
    // is held the ID stage keeps redirect asserted until the stall clears.
    assign redirect_acc = (state_q == RUN) && redirect && PC_WriteEn;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc4_d       = pc4_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        redir_cnt_d = redir_cnt_q;

        case (state_q)
            BOOT: begin
                // First cycle after reset: memory read may not be settled,
                // so issue a bubble and leave the PC where it is. Any
                // redirect seen here is stale and ignored.
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
                state_d = RUN;
            end
            default: begin
                if (!PC_WriteEn)  pc_d = pc_q;
                else if (redirect) pc_d = {redirect_target[31:2], 2'b00};
                else               pc_d = pc_plus4;

                if (!IFID_WriteEn) begin
                    instr_d = instr_q;
                end else if (redirect_acc) begin
                    instr_d = NOP_INSTR;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b0;
                end else begin
                    instr_d = imem_rdata;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                end

                if (Stall_flush && (stall_cnt_q != {CNT_W{1'b1}}))
                    stall_cnt_d = stall_cnt_q + 1'b1;
                if (redirect_acc && (redir_cnt_q != {CNT_W{1'b1}}))
                    redir_cnt_d = redir_cnt_q + 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= BOOT;
            pc_q        <= {RESET_PC[31:2], 2'b00};
            instr_q     <= NOP_INSTR;
            pc4_q       <= 32'h0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pc4_q       <= pc4_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign imem_addr    = pc_q;
    assign IFID_Instr   = instr_q;
    assign IFID_PC4     = pc4_q;
    assign IFID_Valid   = valid_q;
    assign stall_cnt    = stall_cnt_q;
    assign redirect_cnt = redir_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed steps followed by random traffic,
// every cycle compared against a behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    logic             clk = 1'b0;
    logic             reset_n;
    logic             PC_WriteEn, IFID_WriteEn, Stall_flush, redirect;
    logic [31:0]      redirect_target;
    logic [31:0]      imem_addr, imem_rdata;
    logic [31:0]      IFID_Instr, IFID_PC4;
    logic             IFID_Valid;
    logic [CNT_W-1:0] stall_cnt, redirect_cnt;

    int checks = 0;
    int errors = 0;

    fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(32'h0), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .PC_WriteEn(PC_WriteEn), .IFID_WriteEn(IFID_WriteEn),
        .Stall_flush(Stall_flush), .redirect(redirect),
        .redirect_target(redirect_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .IFID_Instr(IFID_Instr), .IFID_PC4(IFID_PC4), .IFID_Valid(IFID_Valid),
        .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: word 0 is addi $t0,$0,5, the rest a hash.
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
    endfunction

    assign imem_rdata = mem(imem_addr);

    // Reference model state
    bit               m_boot;
    logic [31:0]      m_pc, m_instr, m_pc4;
    logic             m_valid;
    logic [CNT_W-1:0] m_scnt, m_rcnt;

    task automatic model_reset();
        m_boot = 1; m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
        m_valid = 0; m_scnt = '0; m_rcnt = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("imem_addr", imem_addr, m_pc);
        chk("IFID_Instr", IFID_Instr, m_instr);
        chk("IFID_PC4", IFID_PC4, m_pc4);
        chk("IFID_Valid", {31'b0, IFID_Valid}, {31'b0, m_valid});
        chk("stall_cnt", {16'b0, stall_cnt}, {16'b0, m_scnt});
        chk("redirect_cnt", {16'b0, redirect_cnt}, {16'b0, m_rcnt});
    endtask

    // One clock: drive inputs, advance the model by the fetch rules, compare.
    task automatic cycle(input logic pwe, input logic iwe, input logic sf,
                         input logic rd, input logic [31:0] tgt, input bit do_chk);
        logic [31:0] fetched;
        bit          taken;
        PC_WriteEn = pwe; IFID_WriteEn = iwe; Stall_flush = sf;
        redirect = rd; redirect_target = tgt;
        fetched = mem(m_pc);
        @(posedge clk);
        #1;
        if (m_boot) begin
            m_boot = 0; m_instr = 32'h0; m_valid = 0;
        end else begin
            taken = rd && pwe;
            if (sf && m_scnt != CMAX) m_scnt = m_scnt + 1;
            if (taken && m_rcnt != CMAX) m_rcnt = m_rcnt + 1;
            if (iwe) begin
                m_pc4 = m_pc + 32'd4;
                m_instr = taken ? 32'h0 : fetched;
                m_valid = !taken;
            end
            if (pwe) m_pc = rd ? (tgt & 32'hFFFF_FFFC) : m_pc + 32'd4;
        end
        if (do_chk) check_all();
    endtask

    initial begin
        int r;
        bit warned = 0;
        reset_n = 0; PC_WriteEn = 1; IFID_WriteEn = 1; Stall_flush = 0;
        redirect = 0; redirect_target = 32'h0;
        model_reset();

        // Reset held for three edges
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_addr", imem_addr, 32'h0);
            chk("rst_valid", {31'b0, IFID_Valid}, 32'h0);
        end
        check_all();
        reset_n = 1;

        // BOOT edge, then first real fetch
        cycle(1, 1, 0, 0, 32'h0, 1);
        chk("boot_addr", imem_addr, 32'h0);
        chk("boot_valid", {31'b0, IFID_Valid}, 32'h0);
        cycle(1, 1, 0, 0, 32'h0, 1);
        chk("first_instr", IFID_Instr, 32'h2008_0005);
        chk("first_pc4", IFID_PC4, 32'h4);
        chk("first_valid", {31'b0, IFID_Valid}, 32'h1);

        // Sequential fetch up to PC=8
        cycle(1, 1, 0, 0, 32'h0, 1);
        chk("seq_addr", imem_addr, 32'h8);

        // Load-use stall at PC=8
        cycle(0, 0, 1, 0, 32'h0, 1);
        chk("stall_addr", imem_addr, 32'h8);
        chk("stall_pc4", IFID_PC4, 32'h8);
        chk("stall_cnt1", {16'b0, stall_cnt}, 32'h1);
        cycle(1, 1, 0, 0, 32'h0, 1);
        chk("resume_addr", imem_addr, 32'hC);
        cycle(1, 1, 0, 0, 32'h0, 1);

        // Redirect at PC=0x10 to 0x40
        cycle(1, 1, 0, 1, 32'h40, 1);
        chk("redir_addr", imem_addr, 32'h40);
        chk("redir_valid", {31'b0, IFID_Valid}, 32'h0);
        chk("redir_instr", IFID_Instr, 32'h0);
        cycle(1, 1, 0, 0, 32'h0, 1);
        chk("redir_pc4", IFID_PC4, 32'h44);
        chk("redir_valid2", {31'b0, IFID_Valid}, 32'h1);
        chk("redir_cnt1", {16'b0, redirect_cnt}, 32'h1);

        // Redirect held across a two-cycle stall
        cycle(0, 0, 1, 1, 32'h123, 1);
        cycle(0, 0, 1, 1, 32'h123, 1);
        chk("rstall_addr", imem_addr, 32'h44);
        cycle(1, 1, 0, 1, 32'h123, 1);
        chk("rstall_tgt", imem_addr, 32'h120);
        chk("rstall_cnt", {16'b0, redirect_cnt}, 32'h2);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 19);
            if (r < 4)
                cycle(0, 0, 1, 1'($urandom_range(0, 1)), $urandom, 1);
            else if (r < 7)
                cycle(1, 1, 0, 1, $urandom, 1);
            else if (r == 7) begin
                if (!warned) $display("warning: mismatched enables PC_WriteEn=1 IFID_WriteEn=0");
                warned = 1;
                cycle(1, 0, 0, 0, 32'h0, 1);
            end else
                cycle(1, 1, 0, 0, 32'h0, 1);
        end

        // Counter saturation
        for (int i = 0; i < 65540; i++) cycle(0, 0, 1, 0, 32'h0, 0);
        check_all();
        chk("stall_sat", {16'b0, stall_cnt}, 32'h0000_FFFF);

        // PC wrap
        cycle(1, 1, 0, 1, 32'hFFFF_FFFF, 1);
        chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
        cycle(1, 1, 0, 0, 32'h0, 1);
        chk("wrap_zero", imem_addr, 32'h0);

        // Reset mid-stall, then a stale redirect during BOOT
        PC_WriteEn = 0; IFID_WriteEn = 0; Stall_flush = 1; redirect = 1;
        redirect_target = 32'h200;
        #3 reset_n = 0;
        #1;
        model_reset();
        chk("mrst_addr", imem_addr, 32'h0);
        chk("mrst_instr", IFID_Instr, 32'h0);
        chk("mrst_pc4", IFID_PC4, 32'h0);
        chk("mrst_valid", {31'b0, IFID_Valid}, 32'h0);
        chk("mrst_scnt", {16'b0, stall_cnt}, 32'h0);
        chk("mrst_rcnt", {16'b0, redirect_cnt}, 32'h0);
        @(posedge clk); #1;
        check_all();
        reset_n = 1;
        cycle(1, 1, 0, 1, 32'h200, 1);
        chk("boot_stale", imem_addr, 32'h0);
        cycle(1, 1, 0, 0, 32'h0, 1);
        chk("post_instr", IFID_Instr, 32'h2008_0005);
        for (int i = 0; i < 20; i++) cycle(1, 1, 0, 0, 32'h0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
